// File: rtl/pu_pkg.sv
// pu_pkg: definitions shared by the reg_pu fetch, decode and top level.
//   - width/encoding defaults: PC_W, INSTR_W, HALT_INSTR, CNT_W
//   - fetch FSM state encoding and its enum type
package pu_pkg;

  localparam int          PC_W       = 8;
  localparam int          INSTR_W    = 9;
  localparam logic [8:0]  HALT_INSTR = 9'h1FF;
  localparam int          CNT_W      = 15;

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_FETCH   = 2'd1;
  localparam logic [1:0]  ST_HALTED  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    HALTED = ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/pu_fetch_stage_if.sv
// pu_fetch_stage_if: instruction-memory and fetch-to-decode signals.
//   imem_addr_o  : read address (fetch -> memory)
//   imem_rdata_i : read data, one cycle after its address (memory -> fetch)
//   id_stall_i   : decode cannot accept this cycle
//   br_taken_i / br_target_i : execute-stage redirect
//   if_valid_o / if_instr_o / if_pc_o : issued instruction to decode
// master = fetch stage, slave = memory/decode/execute side.
interface pu_fetch_stage_if #(
  parameter int PC_W    = pu_pkg::PC_W,
  parameter int INSTR_W = pu_pkg::INSTR_W
);
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               id_stall_i;
  logic               br_taken_i;
  logic [PC_W-1:0]    br_target_i;
  logic               if_valid_o;
  logic [INSTR_W-1:0] if_instr_o;
  logic [PC_W-1:0]    if_pc_o;

  modport master (
    output imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    input  imem_rdata_i, id_stall_i, br_taken_i, br_target_i
  );

  modport slave (
    input  imem_addr_o, if_valid_o, if_instr_o, if_pc_o,
    output imem_rdata_i, id_stall_i, br_taken_i, br_target_i
  );
endinterface

// File: rtl/pu_issue_counter.sv
// pu_issue_counter: saturating up-counter with synchronous clear.
//   clock_i, reset_i : clock, async active-high reset
//   clr_i            : clear to zero (wins over en_i)
//   en_i             : count one event
//   count_o          : current count, sticks at all-ones
module pu_issue_counter #(
  parameter int CNT_W = pu_pkg::CNT_W
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pu_fetch_stage.sv
// pu_fetch_stage: instruction fetch for reg_pu. Owns the PC, reads the
// synchronous instruction memory and issues one instruction per cycle.
//   clock_i, reset_i : clock, async active-high reset
//   start_i, start_addr_i : launch/restart fetch at start_addr_i
//   bus (master)     : memory address/data, decode stall, branch redirect,
//                      issued instruction/PC/valid
//   halted_o         : fetch stopped after issuing HALT_INSTR
//   issue_count_o    : issued-instruction count
// Macro PU_FETCH_PERF_CNT_EN enables the issue counter; otherwise
// issue_count_o is tied to zero.
module pu_fetch_stage #(
  parameter int                 PC_W       = pu_pkg::PC_W,
  parameter int                 INSTR_W    = pu_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] HALT_INSTR = pu_pkg::HALT_INSTR,
  parameter int                 CNT_W      = pu_pkg::CNT_W
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [PC_W-1:0]      start_addr_i,
  pu_fetch_stage_if.master     bus,
  output logic                 halted_o,
  output logic [CNT_W-1:0]     issue_count_o
);
  import pu_pkg::*;

  fetch_state_e      state_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              halted_q;
  logic              in_fetch, issue, halt_hit;

  assign in_fetch = (state_q == FETCH);

  // The memory is addressed with the next PC so its data lines up with
  // pc_q one cycle later; a held PC simply re-reads the same word.
  always_comb begin
    if (start_i)
      pc_d = start_addr_i;
    else if (in_fetch && bus.br_taken_i)
      pc_d = bus.br_target_i;
    else if (bus.id_stall_i || !in_fetch)
      pc_d = pc_q;
    else
      pc_d = pc_q + PC_W'(1);
  end

  assign bus.imem_addr_o = pc_d;
  assign bus.if_valid_o  = in_fetch && !bus.br_taken_i;
  assign bus.if_instr_o  = bus.imem_rdata_i;
  assign bus.if_pc_o     = pc_q;

  assign issue    = bus.if_valid_o && !bus.id_stall_i;
  assign halt_hit = issue && (bus.imem_rdata_i == HALT_INSTR);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          if (start_i) state_q <= FETCH;
        end
        FETCH: begin
          // start restarts in place; the squashed word never issues
          if (!start_i && halt_hit) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (start_i) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted_o = halted_q;

`ifdef PU_FETCH_PERF_CNT_EN
  pu_issue_counter #(.CNT_W(CNT_W)) u_issue_counter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clr_i   (start_i),
    .en_i    (issue),
    .count_o (issue_count_o)
  );
`else
  assign issue_count_o = '0;
`endif

endmodule

// File: tb/tb_pu_fetch_stage.sv
module tb_pu_fetch_stage;

  localparam logic [8:0] HALT = 9'h1FF;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [7:0]  start_addr_i;
  logic        halted_o;
  logic [14:0] issue_count_o;

  pu_fetch_stage_if #(.PC_W(8), .INSTR_W(9)) bus ();

  pu_fetch_stage dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .start_addr_i  (start_addr_i),
    .bus           (bus),
    .halted_o      (halted_o),
    .issue_count_o (issue_count_o)
  );

  always #5 clock_i = ~clock_i;

  // synchronous instruction memory
  logic [8:0] mem [256];
  always @(posedge clock_i) bus.imem_rdata_i <= mem[bus.imem_addr_o];

  int checks = 0;
  int errors = 0;

  // reference model: is fetch running, has it halted, current PC, issue count
  bit       m_run;
  bit       m_halt;
  bit [7:0] m_pc;
  int       m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
`ifdef PU_FETCH_PERF_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_halt = 0;
    m_pc   = 8'd0;
    m_cnt  = 0;
  endtask

  // One cycle: drive inputs, check outputs against the model, clock, advance model.
  task automatic step(input bit st, input bit [7:0] sa, input bit stl,
                      input bit br, input bit [7:0] bt);
    bit [7:0] a;
    bit       v, iss, hit;
    start_i         = st;
    start_addr_i    = sa;
    bus.id_stall_i  = stl;
    bus.br_taken_i  = br;
    bus.br_target_i = bt;
    #1;
    if (st)              a = sa;
    else if (m_run && br) a = bt;
    else if (stl || !m_run) a = m_pc;
    else                 a = m_pc + 8'd1;
    v   = m_run && !br;
    iss = v && !stl;
    hit = iss && (mem[m_pc] == HALT);
    chk("imem_addr", bus.imem_addr_o, a);
    chk("if_valid",  bus.if_valid_o, v);
    chk("if_pc",     bus.if_pc_o, m_pc);
    if (v) chk("if_instr", bus.if_instr_o, mem[m_pc]);
    chk("halted",    halted_o, m_halt);
    chk("count",     issue_count_o, exp_count());
    @(posedge clock_i);
    #1;
    m_pc = a;
    if (st) begin
      m_run = 1; m_halt = 0; m_cnt = 0;
    end else begin
      if (iss && m_cnt < 32767) m_cnt++;
      if (hit) begin
        m_run = 0; m_halt = 1;
      end
    end
  endtask

  task automatic idle_step();
    step(0, 8'd0, 0, 0, 8'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_valid"},  bus.if_valid_o, 1'b0);
    chk({pfx, "_pc"},     bus.if_pc_o, 8'd0);
    chk({pfx, "_addr"},   bus.imem_addr_o, 8'd0);
    chk({pfx, "_halted"}, halted_o, 1'b0);
    chk({pfx, "_count"},  issue_count_o, 15'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, 8'(i)};
    mem[1] = HALT;

    reset_i         = 1'b1;
    start_i         = 1'b0;
    start_addr_i    = 8'd0;
    bus.id_stall_i  = 1'b0;
    bus.br_taken_i  = 1'b0;
    bus.br_target_i = 8'd0;
    #12;
    check_reset_outputs("reset");
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    model_reset();

    // start at 152, run, stall 3 cycles at 155, then branch+stall at 160
    step(1, 8'd152, 0, 0, 8'd0);
    chk("start_pc", bus.if_pc_o, 8'd152);
    repeat (3) idle_step();
    repeat (3) step(0, 8'd0, 1, 0, 8'd0);
    repeat (5) idle_step();
    chk("pre_branch_pc", bus.if_pc_o, 8'd160);
    step(0, 8'd0, 1, 1, 8'd93);
    chk("branch_target_pc", bus.if_pc_o, 8'd93);
    repeat (3) idle_step();

    // wrap through 255 -> 0 and halt at address 1
    step(1, 8'd254, 0, 0, 8'd0);
    repeat (4) idle_step();
    chk("halted_after_wrap", halted_o, 1'b1);
    repeat (3) idle_step();

    // restart from HALTED
    step(1, 8'd138, 0, 0, 8'd0);
    chk("restart_pc", bus.if_pc_o, 8'd138);
    chk("restart_halted", halted_o, 1'b0);
    repeat (3) idle_step();

    // asynchronous reset mid-fetch, away from any clock edge
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;

    // randomized traffic with scattered halt words
    for (int i = 0; i < 256; i++) begin
      logic [8:0] w;
      w = 9'($urandom_range(0, 510));
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : w;
    end
    for (int n = 0; n < 500; n++) begin
      bit st, stl, br;
      st  = ($urandom_range(0, 11) == 0);
      stl = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 5) == 0);
      step(st, 8'($urandom), stl, br, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_fetch_stage.md
# pu_fetch_stage

Instruction-fetch stage of the `reg_pu` pipelined processor. It owns the program counter and is launched by the top-level `start_i`/`start_addr_i` pulse. Each cycle it reads the synchronous instruction memory and issues one instruction plus its PC to decode. It honours decode stalls and execute-stage branch redirects, and stops fetching once it issues the halt instruction.

## Interface
Parameters:
- `PC_W`, 8: PC and instruction-memory address width.
- `INSTR_W`, 9: instruction width.
- `HALT_INSTR`, 9'h1FF: encoding that terminates fetch.
- `CNT_W`, 15: issue-counter width.

Ports:
- `clock_i`  in  1: the block's single clock, rising edge.
- `reset_i`  in  1: asynchronous, active-high reset.
- `start_i`  in  1: launch or restart fetch; sampled on each rising edge.
- `start_addr_i`  in  PC_W: first PC, sampled with `start_i`.
- `imem_addr_o`  out  PC_W: instruction-memory read address, combinational.
- `imem_rdata_i`  in  INSTR_W: memory data, one cycle after its address.
- `id_stall_i`  in  1: decode cannot accept this cycle.
- `br_taken_i`  in  1: execute redirect request.
- `br_target_i`  in  PC_W: redirect target PC.
- `if_valid_o`  out  1: the instruction and PC outputs are meaningful.
- `if_instr_o`  out  INSTR_W: issued instruction, equal to `imem_rdata_i`.
- `if_pc_o`  out  PC_W: PC of `if_instr_o`.
- `halted_o`  out  1: fetch has stopped after issuing the halt instruction.
- `issue_count_o`  out  CNT_W: count of instructions issued.

## Operation
- The FSM states are IDLE, FETCH and HALTED.
- Registers: `pc_q`, `state_q` and `cnt_q`.
- `imem_addr_o` is `pc_next`, so `imem_rdata_i` always corresponds to `pc_q` in FETCH.
- `pc_next` priority, highest first:
  - `start_i`: `start_addr_i`.
  - `br_taken_i` in FETCH: `br_target_i`.
  - `id_stall_i` or not FETCH: `pc_q`.
  - Otherwise: `pc_q + 1`, modulo 2^PC_W, so 8'hFF wraps to 8'h00.
- `if_valid_o` is high when the state is FETCH and `br_taken_i` is low.
- An instruction issues when `if_valid_o` is high and `id_stall_i` is low.
- State transitions:
  - IDLE to FETCH on `start_i`.
  - FETCH to HALTED when an issued instruction equals `HALT_INSTR`; the halt instruction itself is issued.
  - HALTED to FETCH on `start_i`.
  - `start_i` in FETCH restarts: the in-flight instruction is squashed and the PC is reloaded.
- While stalled, the address is held, so the memory re-reads it and the outputs stay stable.
- `halted_o` is high only in HALTED. The top level combines it with pipeline-empty to form `done`.
- Reset mid-operation returns to IDLE immediately. Any in-flight fetch is lost.

## Timing
- Reset values:
  - `state_q` = IDLE, `pc_q` = 0, `cnt_q` = 0.
  - `if_valid_o` = 0, `halted_o` = 0, `issue_count_o` = 0.
  - `if_pc_o` = 0. `if_instr_o` follows memory and is don't-care while invalid.
- Start latency: with `start_i` high at edge t, `if_valid_o` is high from cycle t+1, with `if_pc_o` = `start_addr_i`.
- Throughput is one instruction per cycle when not stalled.
- Redirect: with `br_taken_i` high in cycle c, cycle c is squashed. Cycle c+1 shows the target, one bubble in total.
- Stall and branch in the same cycle: the branch wins.
- Halt is seen combinationally from `imem_rdata_i`. When halt issues at edge t, `halted_o` is high from t+1 and `if_valid_o` is low from t+1.

## Configuration
- `PU_FETCH_PERF_CNT_EN` defined:
  - `cnt_q` is cleared on `start_i`.
  - It increments on each issue and saturates at 2^CNT_W-1.
  - It holds its value through HALTED.
  - `issue_count_o` = `cnt_q`.
- Undefined: the counter logic is absent and `issue_count_o` is tied to 0; the port list is unchanged.

## Structure
- Shared package `pu_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, FETCH=2'd1, HALTED=2'd2);
  - `PC_W`, `INSTR_W`, `HALT_INSTR` and `CNT_W` defaults, shared with decode and the top level.
- Sub-module `pu_issue_counter`: the saturating counter with clear and enable, instantiated only under the macro.

## Test plan
- Reset then start: `start_addr_i`=152, no stalls.
  - `if_pc_o` is 152, 153, 154… on consecutive cycles, `if_valid_o`=1 from cycle 1.
  - `imem_addr_o` leads `if_pc_o` by one.
- Stall: `id_stall_i` high for 3 cycles at PC 155.
  - `if_pc_o` is held at 155 with `if_instr_o` stable.
  - PC 156 appears the cycle after the stall drops.
- Branch: `br_taken_i`=1 with target 93 at PC 160, with `id_stall_i` also high.
  - That cycle shows `if_valid_o`=0.
  - The next cycle shows `if_pc_o`=93, valid.
- Wrap and halt: start at 254 with memory holding halt at address 1.
  - PCs are 254, 255, 0, 1.
  - `halted_o` rises the cycle after PC 1 issues, and `if_valid_o` stays 0 after.
- Restart and reset:
  - `start_i` with address 138 in HALTED: `halted_o` clears and PC 138 issues next cycle.
  - `reset_i` pulsed asynchronously mid-fetch: all outputs return to reset values without a clock edge.
- With `PU_FETCH_PERF_CNT_EN` defined: 5 issues plus 2 stall cycles give `issue_count_o`=5. A restart clears it to 0.
